// File: rtl/dram_arbiter.sv
// Two-master arbiter sharing one DRAM port through an IDLE/ACCESS/DONE FSM.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m0 wins ties.

module dram_arbiter_port #(
    parameter int DATA_W = 32
) (
    input  logic              cpu_clk,
    input  logic              fpga_rstn,
    input  logic              i_sel,
    input  logic              i_rd,
    input  logic [DATA_W-1:0] i_spo,
    output logic              o_gnt,
    output logic [DATA_W-1:0] o_rdata
);
    logic              r_gnt;
    logic [DATA_W-1:0] r_rdata;

    // i_sel is high only in this master's ACCESS cycle, so gnt lands in DONE
    always_ff @(posedge cpu_clk or negedge fpga_rstn) begin
        if (!fpga_rstn) begin
            r_gnt   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_gnt <= i_sel;
            if (i_sel && i_rd)
                r_rdata <= i_spo;
        end
    end

    assign o_gnt   = r_gnt;
    assign o_rdata = r_rdata;
endmodule

module dram_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              cpu_clk,
    input  logic              fpga_rstn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] dram_a,
    output logic              dram_we,
    output logic [DATA_W-1:0] dram_d,
    input  logic [DATA_W-1:0] dram_spo,
    output logic              busy,
    output logic              owner
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        r_state;
    logic              r_last;
    logic              r_owner;
    logic              r_busy;
    logic              r_we_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_wdata_q;

    logic [1:0]             w_req;
    logic                   w_win;
    logic [1:0]             w_sel;
    logic [1:0]             w_gnt;
    logic [1:0][DATA_W-1:0] w_rdata;

    assign w_req = {m1_req, m0_req};

    always_comb begin
        w_win = 1'b0;
        if (w_req == 2'b10)
            w_win = 1'b1;
        else if (w_req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_win = !r_last;
`else
            w_win = 1'b0;
`endif
        end
    end

    // we_q doubles as dram_we: raised for ACCESS only, cleared on the way to DONE
    always_ff @(posedge cpu_clk or negedge fpga_rstn) begin
        if (!fpga_rstn) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_busy    <= 1'b0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_owner   <= w_win;
                        r_we_q    <= w_win ? m1_we    : m0_we;
                        r_addr_q  <= w_win ? m1_addr  : m0_addr;
                        r_wdata_q <= w_win ? m1_wdata : m0_wdata;
                        r_busy    <= 1'b1;
                        r_state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_we_q  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_we_q  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_port
            assign w_sel[g] = (r_state == S_ACCESS) && (r_owner == 1'(g));
            dram_arbiter_port #(.DATA_W(DATA_W)) u_port (
                .cpu_clk   (cpu_clk),
                .fpga_rstn (fpga_rstn),
                .i_sel     (w_sel[g]),
                .i_rd      (!r_we_q),
                .i_spo     (dram_spo),
                .o_gnt     (w_gnt[g]),
                .o_rdata   (w_rdata[g])
            );
        end
    endgenerate

    assign m0_gnt   = w_gnt[0];
    assign m1_gnt   = w_gnt[1];
    assign m0_rdata = w_rdata[0];
    assign m1_rdata = w_rdata[1];
    assign dram_a   = r_addr_q;
    assign dram_d   = r_wdata_q;
    assign dram_we  = r_we_q;
    assign busy     = r_busy;
    assign owner    = r_owner;
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: vector table of single accesses, tie and reset sequences, grant scoreboard.
module tb_dram_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          cpu_clk = 1'b0;
    logic          fpga_rstn = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m1_gnt, dram_we, busy, owner;
    logic [DW-1:0] m0_rdata, m1_rdata, dram_d, dram_spo;
    logic [AW-1:0] dram_a;

    always #5 cpu_clk = ~cpu_clk;

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .cpu_clk(cpu_clk), .fpga_rstn(fpga_rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .dram_a(dram_a), .dram_we(dram_we), .dram_d(dram_d), .dram_spo(dram_spo),
        .busy(busy), .owner(owner)
    );

    // DRAM model: combinational read, clocked write, plus a bench preload port
    logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a = '0;
    logic [DW-1:0] pre_d = '0;
    assign dram_spo = mem[dram_a];
    always @(posedge cpu_clk) begin
        if (dram_we) mem[dram_a] <= dram_d;
        else if (pre_we) mem[pre_a] <= pre_d;
    end

    typedef struct { bit m; bit rd; logic [DW-1:0] data; } exp_t;
    typedef struct { bit m; bit we; logic [AW-1:0] a; logic [DW-1:0] d; logic [DW-1:0] exp; } vec_t;

    exp_t          sb[$];
    exp_t          e_mon;
    vec_t          vt[9];
    logic [DW-1:0] shadow [0:(1<<AW)-1] = '{default: '0};
    logic [DW-1:0] exp_rd [2] = '{default: '0};
    int            total = 0;
    int            bad = 0;
    bit            prev_gnt = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard side: every grant must match the next expected completion
    always @(negedge cpu_clk) begin
        if (fpga_rstn && (m0_gnt || m1_gnt)) begin
            chk("gnt_exclusive", {63'd0, m0_gnt & m1_gnt}, 64'd0);
            chk("gnt_not_consecutive", {63'd0, prev_gnt}, 64'd0);
            if (sb.size() == 0)
                chk("sb_unexpected_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd0);
            else begin
                e_mon = sb.pop_front();
                chk("sb_master", {63'd0, m1_gnt}, {63'd0, e_mon.m});
                if (e_mon.rd)
                    chk("sb_rdata", e_mon.m ? m1_rdata : m0_rdata, e_mon.data);
            end
        end
        prev_gnt = fpga_rstn && (m0_gnt || m1_gnt);
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge cpu_clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge cpu_clk); #1;
        pre_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, {62'd0, m1_gnt, m0_gnt}, 64'd0);
        chk({tag, "_rdata0"}, m0_rdata, 64'd0);
        chk({tag, "_rdata1"}, m1_rdata, 64'd0);
        chk({tag, "_dram_we"}, dram_we, 64'd0);
        chk({tag, "_dram_a"}, dram_a, 64'd0);
        chk({tag, "_dram_d"}, dram_d, 64'd0);
        chk({tag, "_busy_owner"}, {busy, owner}, 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge cpu_clk);
        fpga_rstn = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        @(negedge cpu_clk);
        fpga_rstn = 1'b1;
    endtask

    task automatic run_txn(input vec_t v);
        @(negedge cpu_clk);
        if (v.m) begin m1_req = 1'b1; m1_we = v.we; m1_addr = v.a; m1_wdata = v.d; end
        else     begin m0_req = 1'b1; m0_we = v.we; m0_addr = v.a; m0_wdata = v.d; end
        sb.push_back('{m: v.m, rd: !v.we, data: v.exp});
        @(posedge cpu_clk); #1;
        chk("acc_busy", busy, 64'd1);
        chk("acc_dram_we", dram_we, v.we);
        chk("acc_dram_a", dram_a, v.a);
        chk("acc_dram_d", dram_d, v.d);
        chk("acc_owner", owner, v.m);
        chk("acc_no_gnt", {m1_gnt, m0_gnt}, 64'd0);
        @(posedge cpu_clk); #1;
        chk("done_gnt", {m1_gnt, m0_gnt}, v.m ? 64'd2 : 64'd1);
        chk("done_dram_we", dram_we, 64'd0);
        if (v.we) shadow[v.a] = v.d;
        else      exp_rd[v.m] = v.exp;
        chk("done_rdata0", m0_rdata, exp_rd[0]);
        chk("done_rdata1", m1_rdata, exp_rd[1]);
        if (v.m) m1_req = 1'b0; else m0_req = 1'b0;
        @(posedge cpu_clk); #1;
        chk("idle_busy_gnt", {busy, m1_gnt, m0_gnt}, 64'd0);
    endtask

    task automatic tie_test();
        bit            mk;
        logic [1:0]    ev;
        apply_reset();
        @(negedge cpu_clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0004;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0010;
        for (int k = 0; k < 4; k++) begin
            mk = RR ? k[0] : (k == 3);
            sb.push_back('{m: mk, rd: 1'b1, data: mk ? shadow[14'h0010] : shadow[14'h0004]});
        end
        for (int c = 1; c <= 13; c++) begin
            @(posedge cpu_clk); #1;
            mk = RR ? ((c / 3) % 2 == 1) : (c / 3 == 3);
            ev = (c % 3 == 2) ? (mk ? 2'b10 : 2'b01) : 2'b00;
            chk($sformatf("tie_gnt_c%0d", c), {m1_gnt, m0_gnt}, ev);
            if (c == 8 && !RR) m0_req = 1'b0;
            if (c == 11) begin m0_req = 1'b0; m1_req = 1'b0; end
        end
        exp_rd[0] = shadow[14'h0004];
        exp_rd[1] = shadow[14'h0010];
        chk("tie_rdata0", m0_rdata, exp_rd[0]);
        chk("tie_rdata1", m1_rdata, exp_rd[1]);
    endtask

    task automatic reset_in_access();
        vec_t v;
        @(negedge cpu_clk);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 14'h0020; m1_wdata = 32'hAAAAAAAA;
        @(posedge cpu_clk); #1;
        chk("rst_acc_dram_we", dram_we, 64'd1);
        #2 fpga_rstn = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        m1_req = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        fpga_rstn = 1'b1;
        chk("rst_mem_0020", mem[14'h0020], 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge cpu_clk); #1;
            chk("rst_no_gnt", {busy, m1_gnt, m0_gnt}, 64'd0);
        end
        v = '{m: 1'b0, we: 1'b0, a: 14'h0020, d: 32'h0, exp: 32'h0};
        run_txn(v);
    endtask

    initial begin
        vt[0] = '{m: 1'b1, we: 1'b0, a: 14'h0010, d: 32'h0,        exp: 32'h12345678};
        vt[1] = '{m: 1'b0, we: 1'b1, a: 14'h0004, d: 32'hDEADBEEF, exp: 32'h0};
        vt[2] = '{m: 1'b0, we: 1'b0, a: 14'h0004, d: 32'h0,        exp: 32'hDEADBEEF};
        vt[3] = '{m: 1'b0, we: 1'b1, a: 14'h0030, d: 32'h00000055, exp: 32'h0};
        vt[4] = '{m: 1'b1, we: 1'b0, a: 14'h0030, d: 32'h0,        exp: 32'h00000055};
        vt[5] = '{m: 1'b1, we: 1'b1, a: 14'h3FFF, d: 32'hCAFEF00D, exp: 32'h0};
        vt[6] = '{m: 1'b0, we: 1'b0, a: 14'h3FFF, d: 32'h0,        exp: 32'hCAFEF00D};
        vt[7] = '{m: 1'b1, we: 1'b1, a: 14'h0000, d: 32'hFFFFFFFF, exp: 32'h0};
        vt[8] = '{m: 1'b1, we: 1'b0, a: 14'h0000, d: 32'h0,        exp: 32'hFFFFFFFF};

        #1 fpga_rstn = 1'b0;
        #2;
        check_reset_outputs("reset");
        preload(14'h0010, 32'h12345678);
        @(negedge cpu_clk);
        fpga_rstn = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(vt[i]);
        reset_in_access();
        tie_test();

        repeat (4) @(posedge cpu_clk);
        #1;
        chk("sb_drained", sb.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
